// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants, types and helpers for the 4-line LRU cache controller.
//   NUM_LINES   : number of cache lines tracked
//   CNT_W       : width of one per-line recency counter
//   LINE_W      : width of a line index
//   state_e     : controller FSM states
//   cnt_vec_t   : packed counter vector {cnt3,cnt2,cnt1,cnt0}
//   pick_victim : replacement choice (first invalid line, else count-0 line)
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int NUM_LINES = 4;
   localparam int CNT_W     = 2;
   localparam int LINE_W    = $clog2(NUM_LINES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef logic [NUM_LINES-1:0][CNT_W-1:0] cnt_vec_t;
   typedef logic [LINE_W-1:0]               line_t;

   // Invalid lines are always preferred so a cold cache fills in index order;
   // once full, the line holding count 0 is the least recently used.
   function automatic line_t pick_victim(input logic [NUM_LINES-1:0] valid,
                                         input cnt_vec_t              cnt);
      line_t victim;
      logic  found;
      victim = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (!found && !valid[i]) begin
            victim = line_t'(i);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (cnt[i] == '0) begin
               victim = line_t'(i);
            end
         end
      end
      return victim;
   endfunction

endpackage

// File: rtl/cache_lru_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_lru_ctrl_if
// Request / refill / response bundle of the LRU cache controller.
//   req_valid, req_hit, hit_line : lookup result from the requester
//   req_ready                    : controller can accept a lookup
//   fill_req, fill_line          : refill request toward the backing store
//   fill_ack                     : refill complete
//   done, done_line              : retirement pulse and the line it touched
//   valid_lines, ref_cnt         : observable cache state
// Modports: slave = controller side, master = requester/memory side.
// -----------------------------------------------------------------------------
interface cache_lru_ctrl_if;
   import cache_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_hit;
   line_t                hit_line;
   logic                 fill_req;
   line_t                fill_line;
   logic                 fill_ack;
   logic                 done;
   line_t                done_line;
   logic [NUM_LINES-1:0] valid_lines;
   cnt_vec_t             ref_cnt;

   modport slave (
      input  req_valid, req_hit, hit_line, fill_ack,
      output req_ready, fill_req, fill_line, done, done_line, valid_lines, ref_cnt
   );

   modport master (
      output req_valid, req_hit, hit_line, fill_ack,
      input  req_ready, fill_req, fill_line, done, done_line, valid_lines, ref_cnt
   );

endinterface

// File: rtl/lru_touch.sv
// -----------------------------------------------------------------------------
// lru_touch
// Combinational recency update for one touched line.
//   cnt_i  : current counts (a permutation of 0..NUM_LINES-1)
//   line_i : line being touched
//   cnt_o  : next counts; touched line becomes most recent, every line that
//            was more recent than it moves down by one, the rest are kept,
//            so the result is again a permutation.
// -----------------------------------------------------------------------------
module lru_touch
   import cache_pkg::*;
(
   input  cnt_vec_t cnt_i,
   input  line_t    line_i,
   output cnt_vec_t cnt_o
);

   logic [CNT_W-1:0] touched_cnt;

   always_comb begin
      touched_cnt = cnt_i[line_i];
      cnt_o       = cnt_i;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (line_t'(i) == line_i) begin
            cnt_o[i] = CNT_W'(NUM_LINES - 1);
         end else if (cnt_i[i] > touched_cnt) begin
            cnt_o[i] = cnt_i[i] - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cache_lru_ctrl.sv
// -----------------------------------------------------------------------------
// cache_lru_ctrl
// LRU bookkeeping and refill sequencing for a 4-line cache.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cache_lru_ctrl_if.slave (request, refill and response signals)
// A hit on a valid line updates recency at acceptance and retires the next
// cycle. Anything else picks a victim, requests a refill and retires the
// cycle after fill_ack. One request is in flight at a time.
// -----------------------------------------------------------------------------
module cache_lru_ctrl
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   cache_lru_ctrl_if.slave  bus
);

   state_e               state_q,     state_d;
   cnt_vec_t             cnt_q,       cnt_d;
   logic [NUM_LINES-1:0] valid_q,     valid_d;
   line_t                fill_line_q, fill_line_d;
   line_t                done_line_q, done_line_d;

   line_t                touch_line;
   cnt_vec_t             touch_cnt;

   // In IDLE only a hit can touch; in FILL only the line being refilled can.
   // Kept outside the FSM process so the touch path is not a comb loop.
   assign touch_line = (state_q == ST_IDLE) ? bus.hit_line : fill_line_q;

   lru_touch u_lru_touch (
      .cnt_i  (cnt_q),
      .line_i (touch_line),
      .cnt_o  (touch_cnt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      fill_line_d = fill_line_q;
      done_line_d = done_line_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               // A hit reported on a line we never filled is stale: refill it.
               if (bus.req_hit && valid_q[bus.hit_line]) begin
                  cnt_d       = touch_cnt;
                  done_line_d = bus.hit_line;
                  state_d     = ST_RESP;
               end else begin
                  fill_line_d = pick_victim(valid_q, cnt_q);
                  state_d     = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (bus.fill_ack) begin
               valid_d[fill_line_q] = 1'b1;
               cnt_d                = touch_cnt;
               done_line_d          = fill_line_q;
               state_d              = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         fill_line_q <= '0;
         done_line_q <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            cnt_q[i] <= CNT_W'(i);
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         fill_line_q <= fill_line_d;
         done_line_q <= done_line_d;
      end
   end

   // Handshake outputs decode straight from state, so reset clears them at once.
   assign bus.req_ready   = (state_q == ST_IDLE);
   assign bus.fill_req    = (state_q == ST_FILL);
   assign bus.done        = (state_q == ST_RESP);
   assign bus.fill_line   = fill_line_q;
   assign bus.done_line   = done_line_q;
   assign bus.valid_lines = valid_q;
   assign bus.ref_cnt     = cnt_q;

endmodule

// File: doc/cache_lru_ctrl.md
CACHE_LRU_CTRL -- requirements
Module: cache_lru_ctrl

Interface
REQ-001 The block SHALL have no parameters; line count is 4 and counter width is 2, both fixed via package constants.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  lookup result presented.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_hit  in  1  tag compare hit.
- hit_line  in  2  line index that hit; qualified by req_hit.
- fill_req  out  1  request to refill fill_line.
- fill_line  out  2  line being refilled; stable while fill_req=1.
- fill_ack  in  1  refill complete.
- done  out  1  one-cycle pulse when the request is retired.
- done_line  out  2  line touched by the retired request; valid with done.
- valid_lines  out  4  per-line valid bits.
- ref_cnt  out  8  packed reference counts {cnt3,cnt2,cnt1,cnt0}.

Function
REQ-003 Reference counts SHALL always form a permutation of {0,1,2,3}: 3 = most recent, 0 = least recent.
REQ-004 Touching line L with count c SHALL set cnt[L]=3 and decrement every other count greater than c; all other counts SHALL be unchanged.
REQ-005 The victim SHALL be the lowest-index line with valid=0; if all lines are valid, it SHALL be the line with count 0.
REQ-006 The FSM states SHALL be IDLE, FILL and RESP.
REQ-007 req_ready SHALL be 1 only in IDLE.
REQ-008 On an accepted request with req_hit=1 and valid_lines[hit_line]=1:
- hit_line SHALL be touched on the acceptance edge.
- done_line<=hit_line.
- The FSM SHALL go IDLE->RESP.
REQ-009 On an accepted request with req_hit=0, or with a hit on an invalid line:
- fill_line SHALL be registered with the victim computed from pre-acceptance state.
- The FSM SHALL go IDLE->FILL.
REQ-010 In FILL:
- fill_req SHALL be 1.
- fill_ack SHALL be sampled only in FILL and ignored elsewhere.
- On the edge where fill_ack=1: valid_lines[fill_line]<=1, fill_line SHALL be touched, done_line<=fill_line, and the FSM SHALL go FILL->RESP.
REQ-011 In RESP, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-012 Latency:
- A hit SHALL assert done in the cycle after acceptance.
- A miss SHALL assert done in the cycle after fill_ack.
- Maximum throughput SHALL be one request per 2 cycles.
REQ-013 fill_req SHALL never be asserted in IDLE or RESP; fill_ack arriving in the same cycle as FILL entry SHALL be honoured on the next edge only if still asserted.

Reset
REQ-014 When rst_n=0 at a rising edge, the block SHALL set: state=IDLE, cnt[i]=i, valid_lines=0000, fill_req=0, fill_line=0, done=0, done_line=0.
REQ-015 req_ready SHALL be 1 in the first cycle after reset release.
REQ-016 Reset during FILL or RESP SHALL abandon the operation: no valid bit set, no done pulse, fill_req=0 from the next cycle.

Structure
REQ-017 Package cache_pkg SHALL hold NUM_LINES=4, CNT_W=2, and the FSM state enum.
REQ-018 The touch/update logic SHALL be one combinational sub-module, lru_touch (inputs: current counts, line; output: next counts).

Verification
REQ-019 Reset -> ref_cnt=8'hE4 ({3,2,1,0}), valid_lines=0000, req_ready=1, fill_req=0.
REQ-020 Four misses, each fill_ack given 2 cycles after fill_req -> fill_line sequence 0,1,2,3; valid_lines=1111; counts line0..3={0,1,2,3}; four done pulses.
REQ-021 After REQ-020, hit line1 -> done next cycle with done_line=1; counts line0..3={0,3,1,2}; then a miss -> fill_line=0.
REQ-022 Hit on an invalid line after reset (hit_line=2) -> treated as a miss with fill_line=0, and no count change until fill_ack.
REQ-023 Reset asserted in FILL before fill_ack -> fill_req=0 next cycle, valid_lines unchanged, no done pulse, ref_cnt=8'hE4.
REQ-024 Back-to-back req_valid held high with hits -> accepts spaced exactly 2 cycles; fill_ack pulsed in IDLE has no effect.
